pwr_seq_ctrl: RTL and testbench

PWR_SEQ_CTRL -- requirements
Module: pwr_seq_ctrl

---
 rtl/pwr_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pwr_seq_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pwr_seq_ctrl.sv
// Power sequencer for the clock-mux and LFSR domains: isolate/save/switch-off on
// a down request, ramp/restore/de-isolate on an up request. All outputs registered.
module pwr_seq_ctrl #(
    parameter int ISO_SETUP = 2,
    parameter int RAMP_CYC  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwr_down_req,
    input  logic       pwr_up_req,
    output logic       ck_mx_sw_ctr,
    output logic       lfsr_sw_ctr,
    output logic       iso1,
    output logic       iso2,
    output logic       save_lfsr,
    output logic       restore_lfsr,
    output logic [3:0] pwr_state,
    output logic       busy,
    output logic       ack
);

    typedef enum logic [3:0] {
        ST_ON       = 4'd0,
        ST_ISO      = 4'd1,
        ST_SAVE     = 4'd2,
        ST_LFSR_OFF = 4'd3,
        ST_CK_OFF   = 4'd4,
        ST_OFF      = 4'd5,
        ST_CK_ON    = 4'd6,
        ST_LFSR_ON  = 4'd7,
        ST_RESTORE  = 4'd8,
        ST_DEISO    = 4'd9
    } state_t;

    localparam logic [7:0] ISO_CNT  = 8'(ISO_SETUP);
    localparam logic [7:0] RAMP_CNT = 8'(RAMP_CYC);

    state_t     state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       iso_next, lfsr_next, ck_next, save_next, restore_next, busy_next, ack_next;

    // Next state and dwell counter; the counter is reloaded on entry to each timed state.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_ON: begin
                if (pwr_down_req) begin
                    state_next = ST_ISO;
                    cnt_next   = ISO_CNT;
                end
            end
            ST_ISO: begin
                if (cnt_reg <= 8'd1) begin
                    state_next = ST_SAVE;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            ST_SAVE:     state_next = ST_LFSR_OFF;
            ST_LFSR_OFF: state_next = ST_CK_OFF;
            ST_CK_OFF:   state_next = ST_OFF;
            ST_OFF: begin
                if (pwr_up_req) begin
                    state_next = ST_CK_ON;
                    cnt_next   = RAMP_CNT;
                end
            end
            ST_CK_ON: begin
                if (cnt_reg <= 8'd1) begin
                    state_next = ST_LFSR_ON;
                    cnt_next   = RAMP_CNT;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            ST_LFSR_ON: begin
                if (cnt_reg <= 8'd1) begin
                    state_next = ST_RESTORE;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            ST_RESTORE: begin
                state_next = ST_DEISO;
                cnt_next   = ISO_CNT;
            end
            ST_DEISO: begin
                if (cnt_reg <= 8'd1) begin
                    state_next = ST_ON;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            default: begin
                state_next = ST_ON;
                cnt_next   = 8'd0;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so the registered copies line up with state_reg.
    always_comb begin
        iso_next     = 1'b1;
        lfsr_next    = 1'b1;
        ck_next      = 1'b1;
        save_next    = 1'b0;
        restore_next = 1'b0;
        busy_next    = 1'b1;
        ack_next     = 1'b0;
        case (state_next)
            ST_ON: begin
                iso_next  = 1'b0;
                busy_next = 1'b0;
                ack_next  = (state_reg == ST_DEISO);
            end
            ST_DEISO:    iso_next = 1'b0;
            ST_SAVE:     save_next = 1'b1;
            ST_RESTORE:  restore_next = 1'b1;
            ST_LFSR_OFF: lfsr_next = 1'b0;
            ST_CK_ON:    lfsr_next = 1'b0;
            ST_CK_OFF: begin
                lfsr_next = 1'b0;
                ck_next   = 1'b0;
            end
            ST_OFF: begin
                lfsr_next = 1'b0;
                ck_next   = 1'b0;
                busy_next = 1'b0;
                ack_next  = (state_reg == ST_CK_OFF);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_ON;
            cnt_reg      <= 8'd0;
            ck_mx_sw_ctr <= 1'b1;
            lfsr_sw_ctr  <= 1'b1;
            iso1         <= 1'b0;
            iso2         <= 1'b0;
            save_lfsr    <= 1'b0;
            restore_lfsr <= 1'b0;
            busy         <= 1'b0;
            ack          <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            ck_mx_sw_ctr <= ck_next;
            lfsr_sw_ctr  <= lfsr_next;
            iso1         <= iso_next;
            iso2         <= iso_next;
            save_lfsr    <= save_next;
            restore_lfsr <= restore_next;
            busy         <= busy_next;
            ack          <= ack_next;
        end
    end

    assign pwr_state = state_reg;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Scoreboard bench for pwr_seq_ctrl: two instances (default and minimum dwell) driven
// by the same requests and compared every cycle against a sequence-table model.
module tb_pwr_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pwr_down_req = 1'b0;
    logic pwr_up_req = 1'b0;

    logic       ck0, lf0, ia0, ib0, sv0, rs0, bz0, ak0;
    logic [3:0] ps0;
    logic       ck1, lf1, ia1, ib1, sv1, rs1, bz1, ak1;
    logic [3:0] ps1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: current state code, cycles left in it, ack pending, per-instance dwell params.
    int ms[2] = '{0, 0};
    int ml[2] = '{0, 0};
    int ma[2] = '{0, 0};
    int iso_p[2] = '{2, 1};
    int ramp_p[2] = '{4, 1};
    logic [11:0] q0[$];
    logic [11:0] q1[$];

    always #5 clk = ~clk;

    pwr_seq_ctrl dut0 (
        .clk(clk), .rst(rst), .pwr_down_req(pwr_down_req), .pwr_up_req(pwr_up_req),
        .ck_mx_sw_ctr(ck0), .lfsr_sw_ctr(lf0), .iso1(ia0), .iso2(ib0),
        .save_lfsr(sv0), .restore_lfsr(rs0), .pwr_state(ps0), .busy(bz0), .ack(ak0)
    );

    pwr_seq_ctrl #(.ISO_SETUP(1), .RAMP_CYC(1)) dut1 (
        .clk(clk), .rst(rst), .pwr_down_req(pwr_down_req), .pwr_up_req(pwr_up_req),
        .ck_mx_sw_ctr(ck1), .lfsr_sw_ctr(lf1), .iso1(ia1), .iso2(ib1),
        .save_lfsr(sv1), .restore_lfsr(rs1), .pwr_state(ps1), .busy(bz1), .ack(ak1)
    );

    // Sequence order: ON -> ISO..CK_OFF -> OFF -> CK_ON..DEISO -> ON.
    function automatic int nxt(int s);
        return (s == 9) ? 0 : s + 1;
    endfunction

    function automatic int dur(int s, int i);
        if (s == 1 || s == 9) return iso_p[i];
        if (s == 6 || s == 7) return ramp_p[i];
        return 1;
    endfunction

    // Expected outputs packed as {state, busy, ack, ck_sw, lfsr_sw, iso1, iso2, save, restore}.
    function automatic logic [11:0] expv(int s, int a);
        logic b, k, l, iso, sv, rs;
        b   = !(s == 0 || s == 5);
        k   = !(s == 4 || s == 5);
        l   = !(s >= 3 && s <= 6);
        iso = !(s == 0 || s == 9);
        sv  = (s == 2);
        rs  = (s == 8);
        return {4'(s), b, (a != 0), k, l, iso, iso, sv, rs};
    endfunction

    task automatic chk(string nm, logic [11:0] act, logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // Driver side of the scoreboard: advance the model on each edge and queue expectations.
    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                ms[i] = 0; ml[i] = 0; ma[i] = 0;
            end else begin
                ma[i] = 0;
                if (ms[i] == 0) begin
                    if (pwr_down_req) begin ms[i] = 1; ml[i] = dur(1, i); end
                end else if (ms[i] == 5) begin
                    if (pwr_up_req) begin ms[i] = 6; ml[i] = dur(6, i); end
                end else begin
                    ml[i]--;
                    if (ml[i] == 0) begin
                        ms[i] = nxt(ms[i]);
                        ml[i] = dur(ms[i], i);
                        if (ms[i] == 0 || ms[i] == 5) ma[i] = 1;
                    end
                end
            end
        end
        q0.push_back(expv(ms[0], ma[0]));
        q1.push_back(expv(ms[1], ma[1]));
    end

    // Monitor: outputs are presented every cycle; sample just after the edge.
    always @(posedge clk) begin
        logic [11:0] e0, e1;
        #1;
        if (q0.size() == 0 || q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty cyc=%0d actual=empty required=entry", cyc);
        end else begin
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            chk("dut0_outputs", {ps0, bz0, ak0, ck0, lf0, ia0, ib0, sv0, rs0}, e0);
            chk("dut1_outputs", {ps1, bz1, ak1, ck1, lf1, ia1, ib1, sv1, rs1}, e1);
            if (ak0) $display("ack dut0 cyc=%0d state=%0d", cyc, ps0);
            if (ak1) $display("ack dut1 cyc=%0d state=%0d", cyc, ps1);
        end
    end

    task automatic pulse_down();
        @(negedge clk); pwr_down_req = 1'b1;
        @(negedge clk); pwr_down_req = 1'b0;
    endtask

    task automatic pulse_up();
        @(negedge clk); pwr_up_req = 1'b1;
        @(negedge clk); pwr_up_req = 1'b0;
    endtask

    initial begin
        bit found;
        logic [11:0] rst_vec;
        rst_vec = 12'b0000_0011_0000;

        // Reset held, then idle in ON.
        repeat (3) @(negedge clk);
        chk("reset_dut0", {ps0, bz0, ak0, ck0, lf0, ia0, ib0, sv0, rs0}, rst_vec);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Down sequence with a stray up request during ISO.
        pulse_down();
        pulse_up();
        repeat (8) @(negedge clk);

        // Up sequence with a stray down request during CK_ON.
        pulse_up();
        @(negedge clk);
        pulse_down();
        repeat (14) @(negedge clk);

        // Both requests together from ON: only down applies; hold it past ack.
        @(negedge clk); pwr_down_req = 1'b1; pwr_up_req = 1'b1;
        @(negedge clk); pwr_up_req = 1'b0;
        repeat (10) @(negedge clk);
        pwr_down_req = 1'b0;

        // Power up, then reset asynchronously in LFSR_ON cycle 2 of the default instance.
        pulse_up();
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(posedge clk); #2;
            if (ms[0] == 7 && ml[0] == ramp_p[0] - 1) found = 1'b1;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL wait_lfsr_on actual=timeout required=LFSR_ON");
        end
        rst = 1'b0;
        #1;
        chk("async_rst_dut0", {ps0, bz0, ak0, ck0, lf0, ia0, ib0, sv0, rs0}, rst_vec);
        chk("async_rst_dut1", {ps1, bz1, ak1, ck1, lf1, ia1, ib1, sv1, rs1}, rst_vec);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Randomized request traffic with occasional reset pulses.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            pwr_down_req = ($urandom_range(0, 7) == 0);
            pwr_up_req   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 499) == 0) rst = 1'b0;
            else rst = 1'b1;
        end
        rst = 1'b1;
        pwr_down_req = 1'b0;
        pwr_up_req = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
